score_counter: RTL and testbench

Multi-channel, parametrised up/down score counter: the next generation of the single 7-bit 0–99 counter. Each channel counts rising edges on its increment/decrement strobes with saturation or wrap at a configurable maximum, and supports synchronous load and global clear. The counter sits between the synchronised button inputs and the display decoder path of the scoreboard, one channel per team/display.

---
 rtl/score_pkg.sv | 15 +
 rtl/score_counter_chan.sv | 111 +++++++++++
 rtl/score_counter.sv | 55 +++++
 tb/tb_score_counter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// score_pkg: shared constants for the multi-channel score counter.
//   DEF_NCH     default number of channels
//   DEF_BW      default count width per channel
//   DEF_MAX_VAL default upper count limit
//   SAT_MODE    count sticks at 0 / MAX_VAL
//   WRAP_MODE   count wraps MAX_VAL <-> 0
package score_pkg;

  localparam int DEF_NCH     = 2;
  localparam int DEF_BW      = 7;
  localparam int DEF_MAX_VAL = 99;
  localparam int SAT_MODE    = 0;
  localparam int WRAP_MODE   = 1;

endpackage : score_pkg

// File: rtl/score_counter_chan.sv
// score_counter_chan: one up/down score channel.
//   clk_i       system clock
//   rst_ni      asynchronous active-low reset
//   clr_i       synchronous clear (highest priority)
//   inc_i/dec_i increment/decrement strobes, counted on their rising edge
//   load_i      level-sensitive load enable, load_val_i clamped to MAX_VAL
//   cnt_o       registered count
//   at_max_o    count == MAX_VAL, at_min_o count == 0
//   evt_o       one-cycle pulse when inc/dec changed the count
module score_counter_chan
  import score_pkg::*;
#(
  parameter int BW      = DEF_BW,
  parameter int MAX_VAL = DEF_MAX_VAL,
  parameter int WRAP    = SAT_MODE
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          inc_i,
  input  logic          dec_i,
  input  logic          load_i,
  input  logic [BW-1:0] load_val_i,
  output logic [BW-1:0] cnt_o,
  output logic          at_max_o,
  output logic          at_min_o,
  output logic          evt_o
);

  localparam logic [BW-1:0] MAX_C  = BW'(MAX_VAL);
  localparam logic [BW-1:0] ONE_C  = BW'(1);
  localparam logic [BW-1:0] ZERO_C = BW'(0);

  logic          inc_q, dec_q;
  logic          inc_re, dec_re;
  logic [BW-1:0] cnt_q, cnt_d;
  logic          evt_q, evt_d;
  logic          at_max_q, at_min_q;

  // Next-count logic: clear beats load beats inc/dec; simultaneous edges cancel.
  always_comb begin
    inc_re = inc_i & ~inc_q;
    dec_re = dec_i & ~dec_q;
    cnt_d  = cnt_q;
    evt_d  = 1'b0;
    if (clr_i) begin
      cnt_d = ZERO_C;
      evt_d = 1'b0;
    end else if (load_i) begin
      cnt_d = (load_val_i > MAX_C) ? MAX_C : load_val_i;
      evt_d = 1'b0;
    end else begin
      case ({inc_re, dec_re})
        2'b10: begin
          if (cnt_q < MAX_C) begin
            cnt_d = cnt_q + ONE_C;
            evt_d = 1'b1;
          end else if (WRAP == WRAP_MODE) begin
            cnt_d = ZERO_C;
            evt_d = 1'b1;
          end else begin
            cnt_d = cnt_q;
            evt_d = 1'b0;
          end
        end
        2'b01: begin
          if (cnt_q > ZERO_C) begin
            cnt_d = cnt_q - ONE_C;
            evt_d = 1'b1;
          end else if (WRAP == WRAP_MODE) begin
            cnt_d = MAX_C;
            evt_d = 1'b1;
          end else begin
            cnt_d = cnt_q;
            evt_d = 1'b0;
          end
        end
        default: begin
          cnt_d = cnt_q;
          evt_d = 1'b0;
        end
      endcase
    end
  end

  // State registers; edge registers reset high so a strobe held through reset is ignored.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inc_q    <= 1'b1;
      dec_q    <= 1'b1;
      cnt_q    <= ZERO_C;
      evt_q    <= 1'b0;
      at_max_q <= 1'b0;
      at_min_q <= 1'b1;
    end else begin
      inc_q    <= inc_i;
      dec_q    <= dec_i;
      cnt_q    <= cnt_d;
      evt_q    <= evt_d;
      // Flags registered from the next count so they line up with cnt_q.
      at_max_q <= (cnt_d == MAX_C);
      at_min_q <= (cnt_d == ZERO_C);
    end
  end

  assign cnt_o    = cnt_q;
  assign evt_o    = evt_q;
  assign at_max_o = at_max_q;
  assign at_min_o = at_min_q;

endmodule : score_counter_chan

// File: rtl/score_counter.sv
// score_counter: NCH independent up/down score channels with shared clear.
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   clr_i              synchronous clear of all channels
//   inc_i, dec_i       per-channel rising-edge strobes
//   load_i, load_val_i per-channel load enable and value (channel c at [c*BW +: BW])
//   cnt_o              packed registered counts (channel c at [c*BW +: BW])
//   at_max_o, at_min_o per-channel limit flags
//   evt_o              per-channel count-changed pulse
module score_counter
  import score_pkg::*;
#(
  parameter int NCH     = DEF_NCH,
  parameter int BW      = DEF_BW,
  parameter int MAX_VAL = DEF_MAX_VAL,
  parameter int WRAP    = SAT_MODE
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic [NCH-1:0]    inc_i,
  input  logic [NCH-1:0]    dec_i,
  input  logic [NCH-1:0]    load_i,
  input  logic [NCH*BW-1:0] load_val_i,
  output logic [NCH*BW-1:0] cnt_o,
  output logic [NCH-1:0]    at_max_o,
  output logic [NCH-1:0]    at_min_o,
  output logic [NCH-1:0]    evt_o
);

  // A zero limit or one that does not fit in BW bits cannot be represented.
  if (MAX_VAL <= 0 || MAX_VAL > (2 ** BW) - 1) begin : g_bad_max
    $error("score_counter: MAX_VAL=%0d invalid for BW=%0d", MAX_VAL, BW);
  end

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    score_counter_chan #(
      .BW     (BW),
      .MAX_VAL(MAX_VAL),
      .WRAP   (WRAP)
    ) u_chan (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .clr_i     (clr_i),
      .inc_i     (inc_i[c]),
      .dec_i     (dec_i[c]),
      .load_i    (load_i[c]),
      .load_val_i(load_val_i[c*BW +: BW]),
      .cnt_o     (cnt_o[c*BW +: BW]),
      .at_max_o  (at_max_o[c]),
      .at_min_o  (at_min_o[c]),
      .evt_o     (evt_o[c])
    );
  end

endmodule : score_counter

// File: tb/tb_score_counter.sv
// Testbench: one saturating and one wrapping score_counter driven by the same
// stimulus, each compared every cycle against a behavioural model.
module tb_score_counter;
  import score_pkg::*;

  localparam int NCH  = 2;
  localparam int BW   = 7;
  localparam int MAXV = 99;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clr;
  logic [NCH-1:0]    inc, dec, load;
  logic [NCH*BW-1:0] lv;
  logic [NCH*BW-1:0] cnt_o [2];
  logic [NCH-1:0]    amax_o [2];
  logic [NCH-1:0]    amin_o [2];
  logic [NCH-1:0]    evt_o [2];

  int nvec = 0;
  int nerr = 0;

  // model state: index 0 = saturating, 1 = wrapping
  int m_cnt [2][NCH];
  bit m_evt [2][NCH];
  bit p_inc [NCH];
  bit p_dec [NCH];

  always #5 clk = ~clk;

  score_counter #(.NCH(NCH), .BW(BW), .MAX_VAL(MAXV), .WRAP(SAT_MODE)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .inc_i(inc), .dec_i(dec),
    .load_i(load), .load_val_i(lv), .cnt_o(cnt_o[0]), .at_max_o(amax_o[0]),
    .at_min_o(amin_o[0]), .evt_o(evt_o[0])
  );

  score_counter #(.NCH(NCH), .BW(BW), .MAX_VAL(MAXV), .WRAP(WRAP_MODE)) dut_wrp (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .inc_i(inc), .dec_i(dec),
    .load_i(load), .load_val_i(lv), .cnt_o(cnt_o[1]), .at_max_o(amax_o[1]),
    .at_min_o(amin_o[1]), .evt_o(evt_o[1])
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < NCH; c++) begin
        m_cnt[m][c] = 0;
        m_evt[m][c] = 1'b0;
      end
    for (int c = 0; c < NCH; c++) begin
      p_inc[c] = 1'b1;
      p_dec[c] = 1'b1;
    end
  endfunction

  function automatic void model_step();
    for (int c = 0; c < NCH; c++) begin
      bit ir, dr;
      int ld;
      ir = inc[c] && !p_inc[c];
      dr = dec[c] && !p_dec[c];
      ld = int'(lv[c*BW +: BW]);
      for (int m = 0; m < 2; m++) begin
        m_evt[m][c] = 1'b0;
        if (clr) m_cnt[m][c] = 0;
        else if (load[c]) m_cnt[m][c] = (ld > MAXV) ? MAXV : ld;
        else if (ir && !dr) begin
          if (m_cnt[m][c] < MAXV) begin m_cnt[m][c]++; m_evt[m][c] = 1'b1; end
          else if (m == 1) begin m_cnt[m][c] = 0; m_evt[m][c] = 1'b1; end
        end else if (dr && !ir) begin
          if (m_cnt[m][c] > 0) begin m_cnt[m][c]--; m_evt[m][c] = 1'b1; end
          else if (m == 1) begin m_cnt[m][c] = MAXV; m_evt[m][c] = 1'b1; end
        end
      end
      p_inc[c] = inc[c];
      p_dec[c] = dec[c];
    end
  endfunction

  task automatic check_all(input string tag);
    for (int m = 0; m < 2; m++) begin
      logic [NCH*BW-1:0] ecnt;
      logic [NCH-1:0]    eevt, emax, emin;
      for (int c = 0; c < NCH; c++) begin
        ecnt[c*BW +: BW] = BW'(m_cnt[m][c]);
        eevt[c] = m_evt[m][c];
        emax[c] = (m_cnt[m][c] == MAXV);
        emin[c] = (m_cnt[m][c] == 0);
      end
      check_val({tag, (m == 0) ? "/sat/cnt" : "/wrp/cnt"}, 32'(cnt_o[m]), 32'(ecnt));
      check_val({tag, (m == 0) ? "/sat/evt" : "/wrp/evt"}, 32'(evt_o[m]), 32'(eevt));
      check_val({tag, (m == 0) ? "/sat/max" : "/wrp/max"}, 32'(amax_o[m]), 32'(emax));
      check_val({tag, (m == 0) ? "/sat/min" : "/wrp/min"}, 32'(amin_o[m]), 32'(emin));
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    clr = 1'b0; inc = '0; dec = '0; load = '0;
  endtask

  task automatic pulse_inc(input int c, input string tag);
    inc[c] = 1'b1; cycle(tag);
    inc[c] = 1'b0; cycle(tag);
  endtask

  task automatic pulse_dec(input int c, input string tag);
    dec[c] = 1'b1; cycle(tag);
    dec[c] = 1'b0; cycle(tag);
  endtask

  task automatic load_ch(input int c, input int v, input string tag);
    load[c] = 1'b1; lv[c*BW +: BW] = BW'(v); cycle(tag);
    load[c] = 1'b0; cycle(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    lv = '0;
    inc[0] = 1'b1;       // strobe held high through reset
    model_reset();
    #23;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all("reset");

    // held strobe after reset is not counted; new edge counts once
    for (int i = 0; i < 5; i++) cycle("held_inc");
    check_val("held_inc_cnt0", 32'(cnt_o[0][BW-1:0]), 32'd0);
    inc[0] = 1'b0; cycle("drop");
    inc[0] = 1'b1; cycle("reraise");
    check_val("reraise_evt", 32'(evt_o[0][0]), 32'd1);
    cycle("reraise_hold");
    check_val("evt_one_cycle", 32'(evt_o[0][0]), 32'd0);
    inc[0] = 1'b0; cycle("drop2");

    // saturation at MAX on ch0 (wrap instance rolls over)
    clr = 1'b1; cycle("clr"); clr = 1'b0;
    for (int i = 0; i < 100; i++) pulse_inc(0, "inc100");
    check_val("sat_at_99", 32'(cnt_o[0][BW-1:0]), 32'd99);
    check_val("sat_at_max", 32'(amax_o[0][0]), 32'd1);
    check_val("ch1_untouched", 32'(cnt_o[0][2*BW-1:BW]), 32'd0);
    inc[0] = 1'b1; cycle("inc101");
    check_val("sat_101_evt", 32'(evt_o[0][0]), 32'd0);
    inc[0] = 1'b0; cycle("inc101_low");

    // wrap on ch1 both directions
    pulse_dec(1, "wrap_dec");
    check_val("wrap_dec_cnt", 32'(cnt_o[1][2*BW-1:BW]), 32'd99);
    pulse_inc(1, "wrap_inc");
    check_val("wrap_inc_min", 32'(amin_o[1][1]), 32'd1);

    // simultaneous edges cancel; load clamps
    load_ch(0, 42, "load42");
    inc[0] = 1'b1; dec[0] = 1'b1; cycle("both_edges");
    check_val("both_cnt", 32'(cnt_o[0][BW-1:0]), 32'd42);
    idle(); cycle("both_low");
    load_ch(0, 120, "load120");
    check_val("load_clamp", 32'(cnt_o[1][BW-1:0]), 32'd99);

    // clear beats inc; load beats inc
    load_ch(0, 50, "load50");
    load_ch(1, 7, "load7");
    clr = 1'b1; inc[0] = 1'b1; cycle("clr_vs_inc");
    idle(); cycle("clr_low");
    load[1] = 1'b1; inc[1] = 1'b1; lv[BW +: BW] = BW'(10); cycle("load_vs_inc");
    check_val("load_vs_inc_cnt", 32'(cnt_o[0][2*BW-1:BW]), 32'd10);
    idle(); cycle("load_low");

    // asynchronous reset between clock edges
    load_ch(0, 30, "load30");
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #2;
    rst_n = 1'b1;
    cycle("post_rst");

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      inc  = NCH'($urandom);
      dec  = NCH'($urandom);
      clr  = ($urandom_range(0, 40) == 0);
      load = ($urandom_range(0, 10) == 0) ? NCH'($urandom) : '0;
      for (int c = 0; c < NCH; c++) begin
        case ($urandom_range(0, 4))
          0: lv[c*BW +: BW] = BW'(0);
          1: lv[c*BW +: BW] = BW'(MAXV - 1);
          2: lv[c*BW +: BW] = BW'(MAXV);
          default: lv[c*BW +: BW] = BW'($urandom);
        endcase
      end
      cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule : tb_score_counter
